// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module   : alu_arbiter_pkg
// Brief    : Shared ALU control codes, arbiter state encodings and port indices.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

  // ALU control codes shared with the rv32im alu
  localparam int ALU_CTRL_WIDTH = 4;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD_ADDI = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SUB      = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLL      = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT      = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU     = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR      = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRL      = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRA      = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR       = 4'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND      = 4'd9;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE  = 2'd0,
    ALU_ARB_ISSUE = 2'd1,
    ALU_ARB_RESP  = 2'd2
  } alu_arb_state_t;

  localparam logic ALU_ARB_P0 = 1'b0;
  localparam logic ALU_ARB_P1 = 1'b1;

  function automatic logic alu_is_shift(input logic [ALU_CTRL_WIDTH-1:0] ctrl);
    return (ctrl == ALU_CTRL_SLL) || (ctrl == ALU_CTRL_SRL) || (ctrl == ALU_CTRL_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arb_pick.sv
// ============================================================================
// Module   : alu_arb_pick
// Brief    : Combinational 2-way requester picker. ALU_ARB_RR_EN selects
//            round-robin tie-break; otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  assign any = |valid;

`ifdef ALU_ARB_RR_EN
  always_comb begin
    grant = ALU_ARB_P0;
    if (valid[0] && valid[1]) begin
      grant = ~last_grant;
    end else if (valid[1]) begin
      grant = ALU_ARB_P1;
    end
  end
`else
  always_comb begin
    grant = ALU_ARB_P0;
    if (!valid[0] && valid[1]) begin
      grant = ALU_ARB_P1;
    end
  end

  // Fixed priority never consults the previous winner
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;
`endif

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one ALU between two requesters with a valid/ready issue
//            and a one-cycle done pulse. Define ALU_ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = ALU_CTRL_WIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_valid,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [CTRL_W-1:0] r0_ctrl,
  output logic              r0_ack,
  output logic              r0_done,
  input  logic              r1_valid,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [CTRL_W-1:0] r1_ctrl,
  output logic              r1_ack,
  output logic              r1_done,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_valid,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  alu_arb_state_t    r_state;
  alu_arb_state_t    w_state_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_grant;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_zero;
  logic              w_pick_grant;
  logic              w_pick_any;
  logic              w_pick_last;
  logic              w_accept;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_grant <= ALU_ARB_P1;
    end else if (w_accept) begin
      r_last_grant <= w_pick_grant;
    end
  end

  assign w_pick_last = r_last_grant;
`else
  assign w_pick_last = ALU_ARB_P1;
`endif

  alu_arb_pick u_pick (
    .valid      ({r1_valid, r0_valid}),
    .last_grant (w_pick_last),
    .grant      (w_pick_grant),
    .any        (w_pick_any)
  );

  // Gated by resetn so no ack escapes while the block is held in reset
  assign w_accept = resetn && (r_state == ALU_ARB_IDLE) && w_pick_any;

  always_comb begin
    w_state_next = r_state;
    r0_ack       = 1'b0;
    r1_ack       = 1'b0;
    r0_done      = 1'b0;
    r1_done      = 1'b0;
    alu_valid    = 1'b0;
    busy         = (r_state != ALU_ARB_IDLE);
    case (r_state)
      ALU_ARB_IDLE: begin
        if (w_accept) begin
          r0_ack       = (w_pick_grant == ALU_ARB_P0);
          r1_ack       = (w_pick_grant == ALU_ARB_P1);
          w_state_next = ALU_ARB_ISSUE;
        end
      end
      ALU_ARB_ISSUE: begin
        alu_valid = 1'b1;
        if (alu_ready) begin
          w_state_next = ALU_ARB_RESP;
        end
      end
      ALU_ARB_RESP: begin
        r0_done      = resetn && (r_grant == ALU_ARB_P0);
        r1_done      = resetn && (r_grant == ALU_ARB_P1);
        w_state_next = ALU_ARB_IDLE;
      end
      default: begin
        w_state_next = ALU_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ALU_ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Only the winner's operands are sampled
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_ctrl  <= '0;
      r_grant <= ALU_ARB_P0;
    end else if (w_accept) begin
      r_grant <= w_pick_grant;
      if (w_pick_grant == ALU_ARB_P1) begin
        r_a    <= r1_a;
        r_b    <= r1_b;
        r_ctrl <= r1_ctrl;
      end else begin
        r_a    <= r0_a;
        r_b    <= r0_b;
        r_ctrl <= r0_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if ((r_state == ALU_ARB_ISSUE) && alu_ready) begin
      r_rsp_result <= alu_result;
      r_rsp_zero   <= alu_zero;
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_ctrl;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed bench for alu_arbiter with a behavioural ALU that can act
//            combinationally or as a cycle-based shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int CW = ALU_CTRL_WIDTH;

  logic          clk = 1'b0;
  logic          resetn;
  logic          r0_valid, r1_valid;
  logic [DW-1:0] r0_a, r0_b, r1_a, r1_b;
  logic [CW-1:0] r0_ctrl, r1_ctrl;
  logic          r0_ack, r1_ack, r0_done, r1_done;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic [CW-1:0] alu_ctrl;
  logic          alu_valid, alu_ready, alu_zero, busy;

  logic          shifter_mode;
  logic [5:0]    sh_cnt;
  int            checks = 0;
  int            errors = 0;
  int            n;
  logic [3:0]    exp_tie;
  logic          g;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .r0_valid   (r0_valid),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r0_ctrl    (r0_ctrl),
    .r0_ack     (r0_ack),
    .r0_done    (r0_done),
    .r1_valid   (r1_valid),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .r1_ctrl    (r1_ctrl),
    .r1_ack     (r1_ack),
    .r1_done    (r1_done),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  // Behavioural ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_CTRL_ADD_ADDI: alu_result = alu_a + alu_b;
      ALU_CTRL_SUB:      alu_result = alu_a - alu_b;
      ALU_CTRL_XOR:      alu_result = alu_a ^ alu_b;
      ALU_CTRL_OR:       alu_result = alu_a | alu_b;
      ALU_CTRL_AND:      alu_result = alu_a & alu_b;
      ALU_CTRL_SLL:      alu_result = alu_a << alu_b[4:0];
      ALU_CTRL_SRL:      alu_result = alu_a >> alu_b[4:0];
      ALU_CTRL_SRA:      alu_result = $signed(alu_a) >>> alu_b[4:0];
      default:           alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Shifter completes on ISSUE cycle N+2 (N = shift amount)
  always_ff @(posedge clk) begin
    if (!alu_valid) sh_cnt <= '0;
    else            sh_cnt <= sh_cnt + 6'd1;
  end

  always_comb begin
    alu_ready = alu_valid;
    if (shifter_mode && alu_is_shift(alu_ctrl)) begin
      alu_ready = alu_valid && (sh_cnt == 6'(alu_b[4:0]) + 6'd1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    resetn = 1'b0; shifter_mode = 1'b0;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_ctrl = '0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_ctrl = '0;
`ifdef ALU_ARB_RR_EN
    exp_tie = 4'b1010;
`else
    exp_tie = 4'b0000;
`endif

    // Reset state, with a request pending that must not be acked
    cyc(); cyc();
    r0_valid = 1'b1; #1;
    chk("rst_r0_ack", r0_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_valid", alu_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_a", alu_a, 0);
    r0_valid = 1'b0; resetn = 1'b1;
    cyc();

    // Single port-0 ADD, combinational ALU
    r0_valid = 1'b1; r0_a = 5; r0_b = 7; r0_ctrl = ALU_CTRL_ADD_ADDI; #1;
    chk("add_r0_ack", r0_ack, 1);
    chk("add_r1_ack", r1_ack, 0);
    cyc(); r0_valid = 1'b0;
    chk("add_alu_valid", alu_valid, 1);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 7);
    chk("add_busy", busy, 1);
    chk("add_no_done_t1", r0_done, 0);
    cyc();
    chk("add_r0_done", r0_done, 1);
    chk("add_r1_done", r1_done, 0);
    chk("add_result", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_resp_alu_valid", alu_valid, 0);
    cyc();
    chk("add_done_pulse_end", r0_done, 0);
    chk("add_idle_busy", busy, 0);
    chk("add_result_held", rsp_result, 12);

    // Tie: both held valid across four operations, from a fresh reset
    resetn = 1'b0; cyc(); resetn = 1'b1;
    r0_valid = 1'b1; r0_a = 3;     r0_b = 3;     r0_ctrl = ALU_CTRL_SUB;
    r1_valid = 1'b1; r1_a = 'hF0;  r1_b = 'h0F;  r1_ctrl = ALU_CTRL_XOR; #1;
    for (int k = 0; k < 4; k++) begin
      g = exp_tie[k];
      chk($sformatf("tie%0d_r0_ack", k), r0_ack, !g);
      chk($sformatf("tie%0d_r1_ack", k), r1_ack, g);
      cyc();
      chk($sformatf("tie%0d_alu_a", k), alu_a, g ? 32'hF0 : 32'h3);
      chk($sformatf("tie%0d_no_ack_issue", k), r0_ack | r1_ack, 0);
      cyc();
      chk($sformatf("tie%0d_r0_done", k), r0_done, !g);
      chk($sformatf("tie%0d_r1_done", k), r1_done, g);
      chk($sformatf("tie%0d_result", k), rsp_result, g ? 32'hFF : 32'h0);
      chk($sformatf("tie%0d_zero", k), rsp_zero, !g);
      cyc();
    end
    r0_valid = 1'b0; #1;
    chk("p1_only_r1_ack", r1_ack, 1);
    chk("p1_only_r0_ack", r0_ack, 0);
    cyc(); r1_valid = 1'b0;
    cyc();
    chk("p1_only_r1_done", r1_done, 1);
    chk("p1_only_result", rsp_result, 32'hFF);
    cyc();

    // Cycle-based shifter: SLL 1 by 5
    shifter_mode = 1'b1;
    r0_valid = 1'b1; r0_a = 1; r0_b = 5; r0_ctrl = ALU_CTRL_SLL; #1;
    chk("sll_ack", r0_ack, 1);
    cyc(); r0_valid = 1'b0;
    n = 0;
    while (alu_valid && n < 40) begin
      n++;
      cyc();
    end
    chk("sll_issue_len", n, 7);
    chk("sll_done", r0_done, 1);
    chk("sll_result", rsp_result, 32'h20);
    chk("sll_resp_alu_valid", alu_valid, 0);

    // SRA by 0 requested during RESP; picked in the following IDLE
    r0_valid = 1'b1; r0_a = 32'h8000_0000; r0_b = 0; r0_ctrl = ALU_CTRL_SRA; #1;
    chk("sra_no_ack_in_resp", r0_ack, 0);
    cyc();
    chk("sra_ack_idle", r0_ack, 1);
    chk("sra_gap_alu_valid", alu_valid, 0);
    cyc(); r0_valid = 1'b0;
    n = 0;
    while (alu_valid && n < 40) begin
      n++;
      cyc();
    end
    chk("sra_issue_len", n, 2);
    chk("sra_done", r0_done, 1);
    chk("sra_result", rsp_result, 32'h8000_0000);
    chk("sra_zero", rsp_zero, 0);
    cyc();

    // Reset during a long shift aborts without a done pulse
    r0_valid = 1'b1; r0_a = 1; r0_b = 31; r0_ctrl = ALU_CTRL_SLL; #1;
    chk("abort_ack", r0_ack, 1);
    cyc(); r0_valid = 1'b0;
    cyc(); cyc();
    chk("abort_in_issue", alu_valid, 1);
    resetn = 1'b0;
    cyc();
    chk("abort_busy", busy, 0);
    chk("abort_alu_valid", alu_valid, 0);
    chk("abort_result", rsp_result, 0);
    chk("abort_no_done", r0_done, 0);
    resetn = 1'b1;
    cyc();
    chk("abort_no_done_after", r0_done, 0);

    // Fresh request after reset
    r0_valid = 1'b1; r0_a = 32'h10; r0_b = 32'h20; r0_ctrl = ALU_CTRL_ADD_ADDI; #1;
    chk("fresh_ack", r0_ack, 1);
    cyc(); r0_valid = 1'b0;
    chk("fresh_alu_valid", alu_valid, 1);
    cyc();
    chk("fresh_done", r0_done, 1);
    chk("fresh_result", rsp_result, 32'h30);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single rv32im `alu` instance between two requesters: port 0 is the core's main datapath and port 1 is an auxiliary unit such as a branch-target or address generator. The arbiter picks one request, latches its operands and control, and drives the ALU's `alu_valid`/`alu_ready` handshake until the ALU completes. It then returns a registered result and zero flag to the winning requester as a one-cycle done pulse. It tolerates both the combinational ALU and the variable-latency, cycle-based-shifter ALU.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `CTRL_W`, `ALU_CTRL_WIDTH`: ALU control width, taken from riscv_defines.vh.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset: synchronous, active-low.
- `r0_valid`, `r1_valid`  in  1  request pending; held until the matching ack.
- `r0_a`, `r0_b`, `r1_a`, `r1_b`  in  DATA_W  operands.
- `r0_ctrl`, `r1_ctrl`  in  CTRL_W  ALU control code.
- `r0_ack`, `r1_ack`  out  1  one-cycle pulse: request accepted; operands are latched.
- `r0_done`, `r1_done`  out  1  one-cycle pulse: result valid this cycle.
- `rsp_result`  out  DATA_W  registered result, shared by both ports.
- `rsp_zero`  out  1  registered zero flag.
- `alu_a`, `alu_b`  out  DATA_W  ALU operands.
- `alu_ctrl`  out  CTRL_W  ALU control.
- `alu_valid`  out  1  ALU request.
- `alu_ready`  in  1  ALU completion.
- `alu_result`  in  DATA_W  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `busy`  out  1  state is not IDLE.

## Operation
- State machine: IDLE, ISSUE, RESP.
- **IDLE:**
  - If any `rN_valid` is high, pick a winner and latch `a`, `b`, `ctrl` and the grant index.
  - Pulse the winner's `rN_ack` combinationally in the same cycle.
  - Go to ISSUE.
- **ISSUE:**
  - Drive `alu_valid=1` and `alu_a/b/ctrl` from the latched registers, held stable.
  - When `alu_ready` is high, capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, then go to RESP.
- **RESP:**
  - Pulse the granted port's `rN_done`. `alu_valid` is 0.
  - Go to IDLE.
  - This guaranteed `alu_valid`-low gap is required so the cycle-based shifter can re-arm.
- No new pick happens in ISSUE or RESP; requesters keep `valid` asserted and wait.
- The losing requester's operands are never sampled.
- Outside ISSUE, `alu_a/b/ctrl` hold their last latched values and `alu_valid` is 0.
- `rsp_result`/`rsp_zero` keep their value until the next capture.
- There is no timeout: if `alu_ready` never rises, ISSUE persists.

## Timing
- Reset values: state IDLE; all ack/done pulses 0; `alu_valid` 0; `busy` 0; `rsp_result` 0; `rsp_zero` 0; latched operands 0; `last_grant` 1, so the first round-robin tie goes to port 0.
- Combinational ALU (`alu_ready = alu_valid`):
  - Request seen in IDLE at cycle t; ack at t.
  - ISSUE at t+1, ALU completes at t+1.
  - done and result at t+2.
  - Throughput: one operation per 3 cycles.
- Cycle-based shifter with shift amount N > 0: ISSUE lasts N+2 cycles.
- Shifter with shift amount 0: ISSUE lasts 2 cycles.
- Simultaneous `r0_valid` and `r1_valid`: resolved by the arbitration policy below; exactly one ack.
- A request arriving in RESP is picked in the following IDLE cycle.
- Reset asserted mid-operation:
  - Aborts immediately to IDLE. No done pulse is issued for the aborted operation.
  - `alu_valid` is 0 in the first cycle after reset.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, grant the port not equal to `last_grant`.
  - `last_grant` updates on every ack.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins a tie.
  - The `last_grant` register is not instantiated.

## Structure
- Shared package, alongside riscv_defines.vh:
  - Arbiter state encodings `ALU_ARB_IDLE`, `ALU_ARB_ISSUE`, `ALU_ARB_RESP`, width 2.
  - Requester index constants `ALU_ARB_P0 = 0`, `ALU_ARB_P1 = 1`.
- One sub-module, `alu_arb_pick`:
  - Combinational 2-way picker with inputs valid[1:0] and last_grant; outputs grant and any.
  - Contains the `ALU_ARB_RR_EN` conditional.
- The ALU itself is instantiated by the parent, not inside the arbiter.

## Test plan
- **Single port-0 ADD** with combinational ALU: `r0_a=5`, `r0_b=7`, `ctrl=ALU_CTRL_ADD_ADDI` → `r0_ack` at t, `alu_valid` at t+1, `r0_done` at t+2 with `rsp_result=12`, `rsp_zero=0`.
- **Tie with round-robin enabled**: both valid for 4 operations (port 0 `SUB` 3−3, port 1 `XOR` 0xF0^0x0F) → grants alternate 0,1,0,1; port-0 results give `rsp_result=0` with `rsp_zero=1`; port-1 results give `0xFF`.
- **Tie without `ALU_ARB_RR_EN`**: both held valid → port 0 acked every operation; port 1 acked only after `r0_valid` drops.
- **Cycle-based shifter**: `SLL` of `a=1`, `b=5` → ISSUE lasts 7 cycles; `rsp_result=0x20`; `alu_valid` is low for at least 1 cycle before the next issue. `SRA` of `0x80000000` by 0 → `0x80000000` after a 2-cycle ISSUE.
- **Reset mid-operation**: resetn low during ISSUE of a shift by 31 → next cycle state is IDLE, `alu_valid=0`, `rsp_result=0`, no `r0_done`. A fresh request after reset completes normally.
